// File: rtl/lsu_types.sv
// lsu_types: shared opcode/state enums and beat-count helper for the vector LSU.
package lsu_types;
    typedef enum logic [2:0] {LD_S = 3'd0, ST_S = 3'd1, LD_V = 3'd2, ST_V = 3'd3, LD_VS = 3'd4, ST_VS = 3'd5} lsu_op_e;
    typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} lsu_state_e;
    function automatic int beats(input int lanes, input int elem_w, input int bus_w);
        return lanes * elem_w / bus_w;
    endfunction
endpackage

// File: rtl/lsu_addr_gen.sv
// lsu_addr_gen: beat address register and beat counter; steps by a fixed
// increment or a programmable stride and flags the final beat of an access.
module lsu_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int BEATS  = 2,
    parameter int STEP   = 4,
    parameter int CW     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              use_stride,
    input  logic              step,
    input  logic              vec,
    output logic [ADDR_W-1:0] addr,
    output logic [CW-1:0]     cnt,
    output logic              last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        addr_d = load ? base : step ? addr_q + (use_stride ? stride : ADDR_W'(STEP)) : addr_q;
        cnt_d  = load ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign cnt  = cnt_q;
    assign last = !vec || cnt_q == CW'(BEATS - 1);
endmodule

// File: rtl/vec_lsu_n.sv
// vec_lsu_n: handshaked multi-beat vector/scalar load-store engine; serialises
// an access into BUS_W beats over a req/ack memory port.
module vec_lsu_n
    import lsu_types::*;
#(
    parameter int LANES  = 8,
    parameter int ELEM_W = 8,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32,
    localparam int VEC_W = LANES * ELEM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [BUS_W-1:0]  wdata_esc,
    input  logic [VEC_W-1:0]  wdata_vec,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BUS_W-1:0]  rdata_esc,
    output logic [VEC_W-1:0]  rdata_vec,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [BUS_W-1:0]  mem_rdata
);
    localparam int BEATS = beats(LANES, ELEM_W, BUS_W);
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

    lsu_state_e state_q, state_d;
    logic [2:0]                        op_q, op_d;
    logic [ADDR_W-1:0]                 stride_q, stride_d;
    logic [BUS_W-1:0]                  wesc_q, wesc_d, resc_q, resc_d;
    logic [BEATS-1:0][BUS_W-1:0]       wvec_q, wvec_d, rvec_q, rvec_d;
    logic                              err_q, err_d;
    logic [ADDR_W-1:0]                 addr;
    logic [CW-1:0]                     cnt;
    logic                              last, accept, is_store, strided, vec, bad, beat_ack;

    assign accept   = state_q == IDLE && start;
    assign is_store = op_q[0];
    assign strided  = op_q == LD_VS || op_q == ST_VS;
    assign vec      = op_q inside {LD_V, ST_V, LD_VS, ST_VS};
    assign bad      = op_q > 3'd5 || addr[1:0] != 2'b00 || (strided && stride_q[1:0] != 2'b00);
    assign beat_ack = state_q == REQ && mem_ack;

    lsu_addr_gen #(.ADDR_W(ADDR_W), .BEATS(BEATS), .STEP(BUS_W / 8), .CW(CW)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .base       (base_addr),
        .stride     (stride_q),
        .use_stride (strided),
        .step       (beat_ack),
        .vec        (vec),
        .addr       (addr),
        .cnt        (cnt),
        .last       (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CHECK : IDLE;
            CHECK:   state_d = bad ? DONE : REQ;
            REQ:     state_d = mem_ack && last ? DONE : REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q != IDLE;
        done    = state_q == DONE;
        mem_req = state_q == REQ;
        mem_we  = mem_req && is_store;
        err     = done && err_q;
    end

    assign mem_addr  = addr;
    assign mem_wdata = vec ? wvec_q[cnt] : wesc_q;
    assign rdata_esc = resc_q;
    assign rdata_vec = rvec_q;

    // Load beats land in the lane slice selected by the beat counter.
    always_comb begin
        op_d     = accept ? op : op_q;
        stride_d = accept ? stride : stride_q;
        wesc_d   = accept ? wdata_esc : wesc_q;
        wvec_d   = accept ? wdata_vec : wvec_q;
        err_d    = state_q == CHECK ? bad : err_q;
        resc_d   = resc_q;
        rvec_d   = rvec_q;
        if (beat_ack && !is_store) begin
            if (vec) rvec_d[cnt] = mem_rdata;
            else     resc_d      = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            stride_q <= '0;
            wesc_q   <= '0;
            wvec_q   <= '0;
            err_q    <= 1'b0;
            resc_q   <= '0;
            rvec_q   <= '0;
        end else begin
            op_q     <= op_d;
            stride_q <= stride_d;
            wesc_q   <= wesc_d;
            wvec_q   <= wvec_d;
            err_q    <= err_d;
            resc_q   <= resc_d;
            rvec_q   <= rvec_d;
        end
    end
endmodule

// File: tb/tb_vec_lsu_n.sv
// tb_vec_lsu_n: scoreboard bench; expected beats and completions are queued at
// issue time and checked by an independent memory responder and done monitor.
module tb_vec_lsu_n;
    typedef struct {logic [31:0] a; logic we; logic [31:0] d;} beat_t;
    typedef struct {logic e; int lat; int t0; logic [31:0] esc; logic [63:0] vec;} done_t;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] base_addr = '0, stride = '0, wdata_esc = '0;
    logic [63:0] wdata_vec = '0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata_esc, mem_addr, mem_wdata;
    logic [63:0] rdata_vec;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0, errors = 0, cyc = 0, wait_n = 0, wc = 0;
    beat_t bq[$];
    done_t dq[$];
    done_t md;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_esc = '0;
    logic [63:0] exp_vec = '0;

    vec_lsu_n dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
        .stride(stride), .wdata_esc(wdata_esc), .wdata_vec(wdata_vec), .busy(busy),
        .done(done), .err(err), .rdata_esc(rdata_esc), .rdata_vec(rdata_vec),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: derives the beat list and final result from the op rules.
    task automatic launch(input logic [2:0] o, input logic [31:0] b, input logic [31:0] s,
                          input logic [31:0] e, input logic [63:0] v);
        logic strd, vec, st, bad;
        logic [31:0] a;
        int n;
        done_t d;
        beat_t bt;
        strd = o == 3'd4 || o == 3'd5;
        vec  = o >= 3'd2 && o <= 3'd5;
        st   = o[0];
        bad  = o > 3'd5 || b[1:0] != 2'b00 || (strd && s[1:0] != 2'b00);
        n    = bad ? 0 : (vec ? 2 : 1);
        a    = b;
        for (int k = 0; k < n; k++) begin
            bt.a  = a;
            bt.we = st;
            bt.d  = st ? (vec ? v[k*32 +: 32] : e) : 32'h0;
            if (st) mem[a] = bt.d;
            else if (vec) exp_vec[k*32 +: 32] = rd(a);
            else exp_esc = rd(a);
            bq.push_back(bt);
            a = a + (strd ? s : 32'd4);
        end
        d.e   = bad;
        d.lat = 2 + n * (1 + wait_n);
        d.esc = exp_esc;
        d.vec = exp_vec;
        @(negedge clk);
        start = 1'b1; op = o; base_addr = b; stride = s; wdata_esc = e; wdata_vec = v;
        d.t0 = cyc;
        dq.push_back(d);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input bit poke_done);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == 300) begin
            checks++; errors++;
            $display("FAIL done_timeout got=none exp=done");
            bq.delete(); dq.delete();
        end else if (poke_done) begin
            start = 1'b1; op = 3'd2;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Memory responder: checks each presented beat and acks after wait_n cycles.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack = 1'b0; wc = 0;
        end else if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req got=%0h exp=no_request", mem_addr);
            mem_ack = 1'b1;
        end else begin
            chk("beat_addr", 64'(mem_addr), 64'(bq[0].a));
            chk("beat_we", 64'(mem_we), 64'(bq[0].we));
            if (bq[0].we) chk("beat_wdata", 64'(mem_wdata), 64'(bq[0].d));
            if (wc == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = bq[0].we ? $urandom : rd(bq[0].a);
                void'(bq.pop_front());
                wc = 0;
            end else begin
                mem_ack = 1'b0;
                wc++;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done got=1 exp=0");
            end else begin
                md = dq.pop_front();
                chk("err", 64'(err), 64'(md.e));
                chk("latency", 64'(cyc - md.t0), 64'(md.lat));
                chk("rdata_esc", 64'(rdata_esc), 64'(md.esc));
                chk("rdata_vec", rdata_vec, md.vec);
                chk("busy_at_done", 64'(busy), 64'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] b, s;
        int i;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_req", 64'(mem_req), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_esc", 64'(rdata_esc), 0);
        chk("rst_vec", rdata_vec, 0);
        reset = 1'b1;
        @(negedge clk);

        mem[32'h10] = 32'hDEADBEEF;
        launch(3'd0, 32'h10, 0, 0, 0);                  finish_op(0);
        chk("ld_s_value", 64'(rdata_esc), 64'hDEADBEEF);
        launch(3'd3, 32'h20, 0, 0, 64'h1122334455667788); finish_op(1);
        wait_n = 2;
        launch(3'd4, 32'h100, 32'hFFFFFFF8, 0, 0);      finish_op(0);
        wait_n = 0;
        launch(3'd6, 32'h20, 0, 0, 0);                  finish_op(0);
        launch(3'd0, 32'h13, 0, 0, 0);                  finish_op(1);
        launch(3'd5, 32'h40, 32'h6, 0, 64'h5);          finish_op(0);
        launch(3'd2, 32'hFFFFFFFC, 0, 0, 0);            finish_op(0);

        // A start while the unit is mid-access must be dropped.
        wait_n = 1;
        launch(3'd3, 32'h40, 0, 0, {$urandom, $urandom});
        @(negedge clk); start = 1'b1; op = 3'd0; base_addr = 32'h80;
        @(negedge clk); start = 1'b0;
        finish_op(0);

        for (int r = 0; r < 60; r++) begin
            o = 3'($urandom_range(0, 7));
            b = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) b[1:0] = 2'($urandom_range(1, 3));
            s = 32'($urandom_range(0, 16)) << 2;
            if ($urandom_range(0, 1) == 1) s = 32'd0 - s;
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            wait_n = $urandom_range(0, 3);
            launch(o, b, s, $urandom, {$urandom, $urandom});
            finish_op(1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of the second beat's wait.
        wait_n = 3;
        launch(3'd2, 32'h200, 0, 0, 0);
        for (i = 0; i < 50 && bq.size() != 1; i++) @(negedge clk);
        chk("abort_first_beat_seen", 64'(bq.size()), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_req", 64'(mem_req), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        bq.delete(); dq.delete();
        exp_esc = '0; exp_vec = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_n = 0;
        launch(3'd2, 32'h300, 0, 0, 0);                 finish_op(0);
        launch(3'd0, 32'h10, 0, 0, 0);                  finish_op(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
